// File: rtl/ftdi_emu_pkg.sv
// Shared types and constants for the FTDI 245 sync-FIFO device emulator.
// Holds the startup/TX state encodings, proto_err bit positions and the INIT length.
package ftdi_emu_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } start_state_t;

  typedef enum logic {
    TXS_OPEN,
    TXS_GAP
  } tx_state_t;

  localparam int INIT_CYCLES = 5;

  localparam int ERR_RD_NO_OE = 0;
  localparam int ERR_WR_OE    = 1;
  localparam int ERR_RD_EMPTY = 2;
  localparam int ERR_WR_FULL  = 3;

endpackage

// File: rtl/ftdi_emu_fifo.sv
// Single-clock first-word-fall-through FIFO, 2^ASIZE entries; head valid 1 cycle after push.
// wr_rdy low when full (push ignored); rd_dat reads as zero while empty.
module ftdi_emu_fifo #(
  parameter int DATA  = 8,
  parameter int ASIZE = 4
) (
  input  logic            usb_clk,
  input  logic            rst_n,
  input  logic            wr_vld,
  output logic            wr_rdy,
  input  logic [DATA-1:0] wr_dat,
  output logic            rd_vld,
  input  logic            rd_rdy,
  output logic [DATA-1:0] rd_dat
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DATA-1:0]  r_mem [DEPTH];
  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_cnt;
  logic             w_push;
  logic             w_pop;

  // Occupancy never exceeds DEPTH, so its MSB alone marks full.
  assign wr_rdy = ~r_cnt[ASIZE];
  assign rd_vld = |r_cnt;
  assign w_push = wr_vld & wr_rdy;
  assign w_pop  = rd_vld & rd_rdy;
  assign rd_dat = rd_vld ? r_mem[r_rptr] : '0;

  always_ff @(posedge usb_clk) begin
    if (w_push) r_mem[r_wptr] <= wr_dat;
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ASIZE'(1);
      if (w_pop)  r_rptr <= r_rptr + ASIZE'(1);
      r_cnt <= r_cnt + {{ASIZE{1'b0}}, w_push} - {{ASIZE{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/ftdi_245fifo_emulator.sv
// Device-side FTDI 245 sync-FIFO model: host AXI-stream <-> 245 bus, one word/cycle each way.
// RXF#/TXE# come from registers; TXE# also gaps every TX_PKT words. FTDI_EMU_CHECK_EN adds a protocol checker.
module ftdi_245fifo_emulator
  import ftdi_emu_pkg::*;
#(
  parameter int DSIZE    = 1,
  parameter int RX_ASIZE = 4,
  parameter int TX_ASIZE = 4,
  parameter int TX_PKT   = 512,
  parameter int TX_GAP   = 4
) (
  input  logic               rst_n,
  input  logic               usb_clk,
  input  logic               h2d_tvalid,
  output logic               h2d_tready,
  input  logic [DSIZE*8-1:0] h2d_tdata,
  output logic               d2h_tvalid,
  input  logic               d2h_tready,
  output logic [DSIZE*8-1:0] d2h_tdata,
  output logic               usb_rxf,
  output logic               usb_txe,
  input  logic               usb_oe,
  input  logic               usb_rd,
  input  logic               usb_wr,
  inout  wire  [DSIZE*8-1:0] usb_data,
  inout  wire  [DSIZE-1:0]   usb_be,
  output logic [3:0]         proto_err
);

  localparam int DW = DSIZE * 8;
  localparam int PW = (TX_PKT > 1) ? $clog2(TX_PKT) : 1;
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  start_state_t r_st;
  start_state_t w_st_nxt;
  tx_state_t    r_tx_st;
  tx_state_t    w_tx_nxt;
  logic [2:0]    r_init_cnt;
  logic [PW-1:0] r_pkt_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [DW-1:0] r_last;

  logic          w_run;
  logic          w_h2d_rdy;
  logic          w_h2d_vld;
  logic [DW-1:0] w_h2d_dat;
  logic          w_h2d_pop;
  logic          w_d2h_rdy;
  logic          w_d2h_wr;
  logic          w_pkt_last;
  logic          w_gap_last;
  logic [DW-1:0] w_bus;

  assign w_run      = (r_st == ST_RUN);
  assign h2d_tready = w_h2d_rdy & w_run;
  assign usb_rxf    = ~(w_run & w_h2d_vld);
  assign usb_txe    = ~(w_run & w_d2h_rdy & (r_tx_st == TXS_OPEN));
  assign w_h2d_pop  = ~usb_rd & ~usb_rxf;
  assign w_d2h_wr   = ~usb_wr & ~usb_txe;

  // With nothing queued the bus keeps showing the word the FPGA just consumed.
  assign w_bus    = w_h2d_vld ? w_h2d_dat : r_last;
  assign usb_data = usb_oe ? {DW{1'bz}} : w_bus;
  assign usb_be   = usb_oe ? {DSIZE{1'bz}} : {DSIZE{1'b1}};

  assign w_pkt_last = (TX_PKT > 0) && (TX_GAP > 0) && (r_pkt_cnt == PW'(TX_PKT - 1));
  assign w_gap_last = (r_gap_cnt == GW'(TX_GAP - 1));

  ftdi_emu_fifo #(.DATA(DW), .ASIZE(RX_ASIZE)) u_h2d_fifo (
    .usb_clk (usb_clk),
    .rst_n   (rst_n),
    .wr_vld  (h2d_tvalid & w_run),
    .wr_rdy  (w_h2d_rdy),
    .wr_dat  (h2d_tdata),
    .rd_vld  (w_h2d_vld),
    .rd_rdy  (w_h2d_pop),
    .rd_dat  (w_h2d_dat)
  );

  ftdi_emu_fifo #(.DATA(DW), .ASIZE(TX_ASIZE)) u_d2h_fifo (
    .usb_clk (usb_clk),
    .rst_n   (rst_n),
    .wr_vld  (w_d2h_wr),
    .wr_rdy  (w_d2h_rdy),
    .wr_dat  (usb_data),
    .rd_vld  (d2h_tvalid),
    .rd_rdy  (d2h_tready),
    .rd_dat  (d2h_tdata)
  );

  always_comb begin
    w_st_nxt = r_st;
    w_tx_nxt = r_tx_st;
    if (r_st == ST_INIT && r_init_cnt == 3'(INIT_CYCLES - 1)) w_st_nxt = ST_RUN;
    if (!w_run) begin
      w_tx_nxt = TXS_OPEN;
    end else begin
      case (r_tx_st)
        TXS_OPEN: if (w_d2h_wr && w_pkt_last) w_tx_nxt = TXS_GAP;
        TXS_GAP:  if (w_gap_last) w_tx_nxt = TXS_OPEN;
        default:  w_tx_nxt = TXS_OPEN;
      endcase
    end
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st       <= ST_INIT;
      r_tx_st    <= TXS_OPEN;
      r_init_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_last     <= '0;
    end else begin
      r_st    <= w_st_nxt;
      r_tx_st <= w_tx_nxt;
      if (r_st == ST_INIT) r_init_cnt <= r_init_cnt + 3'd1;
      if (w_d2h_wr) r_pkt_cnt <= w_pkt_last ? '0 : r_pkt_cnt + PW'(1);
      if (r_tx_st == TXS_GAP && !w_gap_last) r_gap_cnt <= r_gap_cnt + GW'(1);
      else r_gap_cnt <= '0;
      if (w_h2d_pop) r_last <= w_h2d_dat;
    end
  end

`ifdef FTDI_EMU_CHECK_EN
  logic       r_oe_q;
  logic [3:0] r_err;
  logic [3:0] w_err_now;

  always_comb begin
    w_err_now               = '0;
    w_err_now[ERR_RD_NO_OE] = ~usb_rd & r_oe_q;
    w_err_now[ERR_WR_OE]    = ~usb_wr & ~usb_oe;
    w_err_now[ERR_RD_EMPTY] = ~usb_rd & usb_rxf;
    w_err_now[ERR_WR_FULL]  = ~usb_wr & usb_txe;
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oe_q <= 1'b1;
      r_err  <= '0;
    end else begin
      r_oe_q <= usb_oe;
      r_err  <= r_err | w_err_now;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (rst_n) assert (w_err_now == 4'b0000)
      else $error("ftdi_245fifo_emulator: protocol violation %b", w_err_now);
  end

  assign proto_err = r_err;
`else
  assign proto_err = 4'b0000;
`endif

endmodule

// File: tb/tb_ftdi_245fifo_emulator.sv
// Directed bench for ftdi_245fifo_emulator with scoreboard queues for both directions.
module tb_ftdi_245fifo_emulator;

  logic       usb_clk    = 1'b0;
  logic       rst_n      = 1'b0;
  logic       h2d_tvalid = 1'b0;
  logic       h2d_tready;
  logic [7:0] h2d_tdata  = 8'h00;
  logic       d2h_tvalid;
  logic       d2h_tready = 1'b0;
  logic [7:0] d2h_tdata;
  logic       usb_rxf;
  logic       usb_txe;
  logic       usb_oe = 1'b1;
  logic       usb_rd = 1'b1;
  logic       usb_wr = 1'b1;
  wire  [7:0] usb_data;
  wire  [0:0] usb_be;
  logic [3:0] proto_err;

  logic       tb_drv  = 1'b0;
  logic [7:0] tb_wdat = 8'h00;

  assign usb_data = tb_drv ? tb_wdat : 8'hzz;
  assign usb_be   = tb_drv ? 1'b0 : 1'bz;

  int checks = 0;
  int errors = 0;
  logic [7:0] h2d_q[$];
  logic [7:0] d2h_q[$];
  logic [3:0] exp_err = 4'b0000;

  always #5 usb_clk = ~usb_clk;

  ftdi_245fifo_emulator #(
    .DSIZE(1), .RX_ASIZE(4), .TX_ASIZE(4), .TX_PKT(8), .TX_GAP(4)
  ) dut (
    .rst_n      (rst_n),
    .usb_clk    (usb_clk),
    .h2d_tvalid (h2d_tvalid),
    .h2d_tready (h2d_tready),
    .h2d_tdata  (h2d_tdata),
    .d2h_tvalid (d2h_tvalid),
    .d2h_tready (d2h_tready),
    .d2h_tdata  (d2h_tdata),
    .usb_rxf    (usb_rxf),
    .usb_txe    (usb_txe),
    .usb_oe     (usb_oe),
    .usb_rd     (usb_rd),
    .usb_wr     (usb_wr),
    .usb_data   (usb_data),
    .usb_be     (usb_be),
    .proto_err  (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge usb_clk);
    @(negedge usb_clk);
  endtask

  task automatic init_window();
    for (int i = 1; i <= 5; i++) begin
      step();
      check("init_tready", h2d_tready, (i == 5) ? 1 : 0);
      check("init_rxf", usb_rxf, 1);
    end
  endtask

  task automatic drain_d2h(input int budget);
    for (int c = 0; c < budget && d2h_q.size() > 0; c++) begin
      if (d2h_tvalid) check("d2h_data", d2h_tdata, d2h_q.pop_front());
      step();
    end
    check("d2h_left", d2h_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int acc;
    int run;
    int gaps;

    @(negedge usb_clk);
    check("rst_rxf", usb_rxf, 1);
    check("rst_txe", usb_txe, 1);
    check("rst_tready", h2d_tready, 0);
    check("rst_tvalid", d2h_tvalid, 0);
    check("rst_tdata", d2h_tdata, 0);
    check("rst_proto", proto_err, 0);
    rst_n = 1'b1;
    init_window();

    // h2d basic: three pushes, then OE# and three RD# cycles
    h2d_tvalid = 1'b1;
    h2d_tdata = 8'h11; h2d_q.push_back(8'h11); step();
    check("rxf_after_push", usb_rxf, 0);
    h2d_tdata = 8'h22; h2d_q.push_back(8'h22); step();
    h2d_tdata = 8'h33; h2d_q.push_back(8'h33); step();
    h2d_tvalid = 1'b0;
    usb_oe = 1'b0; step();
    check("be_driven", usb_be, 1);
    for (int i = 0; i < 3; i++) begin
      usb_rd = 1'b0;
      check("h2d_read", usb_data, h2d_q.pop_front());
      step();
    end
    check("rxf_after_pops", usb_rxf, 1);
    check("bus_last_word", usb_data, 8'h33);
    usb_rd = 1'b1; usb_oe = 1'b1;

    // d2h fill to full with the host stalled
    n = 0;
    for (int c = 0; c < 200 && n < 16; c++) begin
      if (!usb_txe) begin
        usb_wr = 1'b0; tb_drv = 1'b1; tb_wdat = 8'hA0 + 8'(n);
        d2h_q.push_back(8'hA0 + 8'(n));
        n++;
      end else begin
        usb_wr = 1'b1; tb_drv = 1'b0;
      end
      step();
    end
    usb_wr = 1'b1; tb_drv = 1'b0;
    check("d2h_accepted", n, 16);
    check("txe_full", usb_txe, 1);
    check("d2h_tvalid_full", d2h_tvalid, 1);
    for (int i = 0; i < 5; i++) step();
    check("txe_full_after_gap", usb_txe, 1);
    usb_wr = 1'b0; tb_drv = 1'b1; tb_wdat = 8'hEE;
`ifdef FTDI_EMU_CHECK_EN
    exp_err[3] = 1'b1;
`endif
    step();
    usb_wr = 1'b1; tb_drv = 1'b0;
    d2h_tready = 1'b1;
    drain_d2h(40);
    check("d2h_empty_after_drain", d2h_tvalid, 0);
    check("d2h_tdata_zero", d2h_tdata, 0);
    check("proto_after_drop", proto_err, exp_err);

    // Packet gaps under continuous writes with concurrent host drain
    acc = 0; run = 0; gaps = 0;
    for (int c = 0; c < 40; c++) begin
      if (d2h_tvalid) check("gap_d2h_data", d2h_tdata, d2h_q.pop_front());
      if (usb_txe) begin
        run++;
      end else begin
        if (run > 0) begin
          check("gap_len", run, 4);
          check("gap_pos", acc, 8 * (gaps + 1));
          gaps++;
        end
        run = 0;
      end
      if (!usb_txe && acc < 24) begin
        usb_wr = 1'b0; tb_drv = 1'b1; tb_wdat = 8'(8'h40 + acc);
        d2h_q.push_back(8'(8'h40 + acc));
        acc++;
      end else begin
        usb_wr = 1'b1; tb_drv = 1'b0;
      end
      step();
    end
    usb_wr = 1'b1; tb_drv = 1'b0;
    check("gap_count", gaps, 3);
    drain_d2h(10);

    // Concurrent h2d push and pop for 100 cycles
    h2d_tvalid = 1'b1; h2d_tdata = 8'h00; h2d_q.push_back(8'h00);
    usb_oe = 1'b0;
    step();
    for (int i = 1; i <= 100; i++) begin
      h2d_tdata = 8'(i); h2d_q.push_back(8'(i));
      usb_rd = 1'b0;
      check("conc_read", usb_data, h2d_q.pop_front());
      step();
      check("conc_rxf", usb_rxf, 0);
    end
    h2d_tvalid = 1'b0;
    check("conc_q_size", h2d_q.size(), 1);
    check("conc_last_read", usb_data, h2d_q.pop_front());
    step();
    usb_rd = 1'b1; usb_oe = 1'b1;
    check("conc_rxf_empty", usb_rxf, 1);

    // Reset in the middle of a 10-word read burst
    h2d_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      h2d_tdata = 8'(8'hC0 + i); h2d_q.push_back(8'(8'hC0 + i));
      step();
    end
    h2d_tvalid = 1'b0;
    usb_oe = 1'b0; step();
    for (int i = 0; i < 4; i++) begin
      usb_rd = 1'b0;
      check("burst_read", usb_data, h2d_q.pop_front());
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rxf", usb_rxf, 1);
    check("midrst_txe", usb_txe, 1);
    check("midrst_tready", h2d_tready, 0);
    h2d_q.delete();
    exp_err = 4'b0000;
    usb_rd = 1'b1; usb_oe = 1'b1;
    @(negedge usb_clk);
    check("midrst_proto", proto_err, exp_err);
    rst_n = 1'b1;
    init_window();
    check("post_rst_rxf_empty", usb_rxf, 1);
    check("post_rst_d2h_empty", d2h_tvalid, 0);

    // Illegal accesses: RD# without prior OE#, then WR# during OE#
    h2d_tvalid = 1'b1; h2d_tdata = 8'h5A; step();
    h2d_tvalid = 1'b0;
    usb_rd = 1'b0; step();
    usb_rd = 1'b1;
`ifdef FTDI_EMU_CHECK_EN
    exp_err[0] = 1'b1;
`endif
    check("proto_rd_no_oe", proto_err, exp_err);
    check("rd_popped_anyway", usb_rxf, 1);
    usb_oe = 1'b0; usb_wr = 1'b0;
    d2h_q.push_back(8'h5A);
    step();
    usb_oe = 1'b1; usb_wr = 1'b1;
`ifdef FTDI_EMU_CHECK_EN
    exp_err[1] = 1'b1;
`endif
    check("proto_wr_oe", proto_err, exp_err);
    drain_d2h(5);
    rst_n = 1'b0;
    @(negedge usb_clk);
    check("proto_cleared", proto_err, 0);
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
